// File: rtl/reorder_buffer_pkg.sv
// Shared types, sizes and tag helpers for the reorder buffer.
// Tags are slot index + 1 so that tag 0 can mean "no producer".
package reorder_buffer_pkg;

   localparam int unsigned ROB_SIZE = 16;
   localparam int unsigned ROB_ID_W = 5;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned PTR_W    = $clog2(ROB_SIZE);
   localparam int unsigned CNT_W    = PTR_W + 1;

   typedef logic [ROB_ID_W-1:0] rob_id_t;
   typedef logic [REG_W-1:0]    reg_t;
   typedef logic [DATA_W-1:0]   word_t;
   typedef logic [PTR_W-1:0]    ptr_t;
   typedef logic [CNT_W-1:0]    cnt_t;

   localparam rob_id_t ZERO_ROB  = '0;
   localparam reg_t    ZERO_REG  = '0;
   localparam word_t   ZERO_WORD = '0;

   typedef struct packed {
      logic  busy;
      logic  ready;
      reg_t  rd;
      logic  is_jump;
      logic  pred_taken;
      logic  taken;
      word_t value;
      word_t target;
   } rob_entry_t;

   function automatic ptr_t tag_to_idx(input rob_id_t tag);
      return ptr_t'(tag - rob_id_t'(1));
   endfunction

   function automatic rob_id_t idx_to_tag(input ptr_t idx);
      return rob_id_t'(idx) + rob_id_t'(1);
   endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatcher, CDB and commit signals of the reorder buffer, grouped in one bundle.
// The slave modport is the ROB side; the master modport is its environment.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic    ena_from_dsp;
   reg_t    rd_from_dsp;
   logic    is_jump_from_dsp;
   logic    pred_taken_from_dsp;
   rob_id_t rob_id_to_dsp;
   logic    full_to_dsp;

   rob_id_t Q1_from_dsp;
   rob_id_t Q2_from_dsp;
   logic    rdy1_to_dsp;
   logic    rdy2_to_dsp;
   word_t   V1_to_dsp;
   word_t   V2_to_dsp;

   logic    cdb_valid;
   rob_id_t cdb_rob_id;
   word_t   cdb_value;
   logic    cdb_taken;
   word_t   cdb_target;

   logic    commit_flag_to_reg;
   logic    commit_jump_flag_to_reg;
   reg_t    rd_to_reg;
   rob_id_t Q_to_reg;
   word_t   V_to_reg;
   word_t   pc_to_if;

   modport slave (
      input  ena_from_dsp, rd_from_dsp, is_jump_from_dsp, pred_taken_from_dsp,
      input  Q1_from_dsp, Q2_from_dsp,
      input  cdb_valid, cdb_rob_id, cdb_value, cdb_taken, cdb_target,
      output rob_id_to_dsp, full_to_dsp,
      output rdy1_to_dsp, rdy2_to_dsp, V1_to_dsp, V2_to_dsp,
      output commit_flag_to_reg, commit_jump_flag_to_reg,
      output rd_to_reg, Q_to_reg, V_to_reg, pc_to_if
   );

   modport master (
      output ena_from_dsp, rd_from_dsp, is_jump_from_dsp, pred_taken_from_dsp,
      output Q1_from_dsp, Q2_from_dsp,
      output cdb_valid, cdb_rob_id, cdb_value, cdb_taken, cdb_target,
      input  rob_id_to_dsp, full_to_dsp,
      input  rdy1_to_dsp, rdy2_to_dsp, V1_to_dsp, V2_to_dsp,
      input  commit_flag_to_reg, commit_jump_flag_to_reg,
      input  rd_to_reg, Q_to_reg, V_to_reg, pc_to_if
   );

endinterface

// File: rtl/rob_query_port.sv
// Operand tag lookup into the reorder buffer: ready flag and value for one tag.
// ROB_CDB_BYPASS_EN additionally reports a same-cycle CDB broadcast as ready.
module rob_query_port
   import reorder_buffer_pkg::*;
(
   input  rob_id_t             q_i,
   input  logic [ROB_SIZE-1:0] busy_i,
   input  logic [ROB_SIZE-1:0] ready_i,
   input  word_t               value_i [ROB_SIZE],
   input  logic                cdb_valid_i,
   input  rob_id_t             cdb_rob_id_i,
   input  word_t               cdb_value_i,
   output logic                rdy_o,
   output word_t               val_o
);

   ptr_t idx;
   logic tag_valid;
   logic stored_rdy;

   assign idx        = tag_to_idx(q_i);
   assign tag_valid  = (q_i != ZERO_ROB);
   assign stored_rdy = tag_valid && busy_i[idx] && ready_i[idx];

`ifdef ROB_CDB_BYPASS_EN
   logic bypass_hit;

   assign bypass_hit = tag_valid && cdb_valid_i && (cdb_rob_id_i == q_i) && busy_i[idx];

   always_comb begin
      rdy_o = stored_rdy || bypass_hit;
      val_o = bypass_hit ? cdb_value_i : value_i[idx];
   end
`else
   logic unused_cdb;

   assign unused_cdb = ^{cdb_valid_i, cdb_rob_id_i, cdb_value_i};

   always_comb begin
      rdy_o = stored_rdy;
      val_o = value_i[idx];
   end
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates tags, collects CDB results, commits in order.
// Optional ROB_CDB_BYPASS_EN enables same-cycle CDB forwarding on the operand query ports.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   reorder_buffer_if.slave  rob_io
);

   rob_entry_t entries_q [ROB_SIZE];
   rob_entry_t entries_d [ROB_SIZE];
   ptr_t       head_q, head_d;
   ptr_t       tail_q, tail_d;
   cnt_t       count_q, count_d;

   logic       commit_flag_q, commit_flag_d;
   logic       jump_flag_q, jump_flag_d;
   reg_t       rd_q, rd_d;
   rob_id_t    tag_q, tag_d;
   word_t      val_q, val_d;
   word_t      pc_q, pc_d;

   logic       full;
   logic       alloc;
   ptr_t       wb_idx;
   logic       wb_hit;
   rob_entry_t head_entry;
   logic       commit;
   logic       mispredict;

   logic [ROB_SIZE-1:0] busy_vec;
   logic [ROB_SIZE-1:0] ready_vec;
   word_t               value_vec [ROB_SIZE];

   assign full       = (count_q == cnt_t'(ROB_SIZE));
   assign alloc      = rob_io.ena_from_dsp && !full;
   assign wb_idx     = tag_to_idx(rob_io.cdb_rob_id);
   assign wb_hit     = rob_io.cdb_valid && (rob_io.cdb_rob_id != ZERO_ROB) &&
                       entries_q[wb_idx].busy;
   assign head_entry = entries_q[head_q];
   assign commit     = head_entry.busy && head_entry.ready;
   assign mispredict = commit && head_entry.is_jump &&
                       (head_entry.taken != head_entry.pred_taken);

   always_comb begin
      entries_d     = entries_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      commit_flag_d = 1'b0;
      jump_flag_d   = 1'b0;
      rd_d          = rd_q;
      tag_d         = tag_q;
      val_d         = val_q;
      pc_d          = pc_q;

      if (alloc) begin
         entries_d[tail_q] = '{busy:       1'b1,
                               ready:      1'b0,
                               rd:         rob_io.rd_from_dsp,
                               is_jump:    rob_io.is_jump_from_dsp,
                               pred_taken: rob_io.pred_taken_from_dsp,
                               taken:      1'b0,
                               value:      ZERO_WORD,
                               target:     ZERO_WORD};
         tail_d = tail_q + ptr_t'(1);
      end

      if (wb_hit) begin
         entries_d[wb_idx].ready  = 1'b1;
         entries_d[wb_idx].value  = rob_io.cdb_value;
         entries_d[wb_idx].taken  = rob_io.cdb_taken;
         entries_d[wb_idx].target = rob_io.cdb_target;
      end

      if (commit) begin
         entries_d[head_q].busy  = 1'b0;
         entries_d[head_q].ready = 1'b0;
         head_d        = head_q + ptr_t'(1);
         commit_flag_d = 1'b1;
         rd_d          = head_entry.rd;
         tag_d         = idx_to_tag(head_q);
         val_d         = head_entry.value;
      end

      if (alloc && !commit) begin
         count_d = count_q + cnt_t'(1);
      end else if (!alloc && commit) begin
         count_d = count_q - cnt_t'(1);
      end

      // A flush overrides this edge's allocation and writeback: every slot is freed.
      if (mispredict) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            entries_d[i].busy  = 1'b0;
            entries_d[i].ready = 1'b0;
         end
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         jump_flag_d = 1'b1;
         pc_d        = head_entry.target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            entries_q[i] <= '0;
         end
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         commit_flag_q <= 1'b0;
         jump_flag_q   <= 1'b0;
         rd_q          <= ZERO_REG;
         tag_q         <= ZERO_ROB;
         val_q         <= ZERO_WORD;
         pc_q          <= ZERO_WORD;
      end else begin
         entries_q     <= entries_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         commit_flag_q <= commit_flag_d;
         jump_flag_q   <= jump_flag_d;
         rd_q          <= rd_d;
         tag_q         <= tag_d;
         val_q         <= val_d;
         pc_q          <= pc_d;
      end
   end

   always_comb begin
      for (int i = 0; i < ROB_SIZE; i++) begin
         busy_vec[i]  = entries_q[i].busy;
         ready_vec[i] = entries_q[i].ready;
         value_vec[i] = entries_q[i].value;
      end
   end

   rob_query_port u_query1 (
      .q_i          (rob_io.Q1_from_dsp),
      .busy_i       (busy_vec),
      .ready_i      (ready_vec),
      .value_i      (value_vec),
      .cdb_valid_i  (rob_io.cdb_valid),
      .cdb_rob_id_i (rob_io.cdb_rob_id),
      .cdb_value_i  (rob_io.cdb_value),
      .rdy_o        (rob_io.rdy1_to_dsp),
      .val_o        (rob_io.V1_to_dsp)
   );

   rob_query_port u_query2 (
      .q_i          (rob_io.Q2_from_dsp),
      .busy_i       (busy_vec),
      .ready_i      (ready_vec),
      .value_i      (value_vec),
      .cdb_valid_i  (rob_io.cdb_valid),
      .cdb_rob_id_i (rob_io.cdb_rob_id),
      .cdb_value_i  (rob_io.cdb_value),
      .rdy_o        (rob_io.rdy2_to_dsp),
      .val_o        (rob_io.V2_to_dsp)
   );

   assign rob_io.rob_id_to_dsp           = idx_to_tag(tail_q);
   assign rob_io.full_to_dsp             = full;
   assign rob_io.commit_flag_to_reg      = commit_flag_q;
   assign rob_io.commit_jump_flag_to_reg = jump_flag_q;
   assign rob_io.rd_to_reg               = rd_q;
   assign rob_io.Q_to_reg                = tag_q;
   assign rob_io.V_to_reg                = val_q;
   assign rob_io.pc_to_if                = pc_q;

endmodule
